mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- E-stage multiply/divide unit with architectural HI/LO registers.
- Feeds HI_E/LO_E into the E-to-M pipeline register; its busy output drives the hazard unit's stall for MFHI/MFLO/MTHI/MTLO and for mult/div ops that arrive while busy.
- Models fixed multi-cycle latency: the result is computed at start, held internally, and committed to HI/LO when the countdown expires.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  E-stage instruction is an md op; qualified by op.
- op  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 treated as none.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- flush  input  1  exception/interrupt taken this cycle; the E-stage instruction is killed.
- busy  output  1  countdown active.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
Reset:
- reset=0 at any time, including mid-operation, immediately clears HI, LO, pending result, count and busy to 0.
- A pending result is discarded.

Accepting a command:
- A command is accepted on a rising edge when start=1, flush=0, busy=0 and op is 1..10 (7..10 only with the feature enabled).
- When start=1 with busy=1, the command is ignored. The hazard unit must stall, so the bench flags this as a protocol error.
- When flush=1, the command is suppressed entirely: no state change, busy stays 0.
- flush does not abort an operation already counting. The owning instruction has passed M and is committed.

MTHI/MTLO:
- Write A into HI (MTHI) or LO (MTLO) at the accepting edge.
- busy stays 0; the new value is visible the next cycle.

MULT/MULTU:
- {pHI,pLO} = 64-bit product of A and B, signed or unsigned, captured at the accepting edge.
- count is loaded with MULT_CYCLES; busy=1 from the next cycle.

DIV/DIVU:
- pLO = quotient, pHI = remainder.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
- count is loaded with DIV_CYCLES.
- Divide by zero: the operation still occupies DIV_CYCLES, and HI/LO are left unchanged at commit.

Countdown and commit:
- count decrements each cycle while nonzero. busy = (count != 0).
- On the edge where count goes 1 -> 0, {HI,LO} <= {pHI,pLO} and busy falls.
- Net effect: busy is high for exactly N cycles, and the new HI/LO are visible in the cycle busy first reads 0.

Other rules:
- A back-to-back start in the cycle busy falls is accepted normally.
- HI/LO are never updated by a suppressed (flushed) op or by op 0 / 11-15.
- All arithmetic uses full 64-bit width; no truncation before commit.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MADD/MADDU: {HI,LO} + A*B, 64-bit with wrap-around.
  - MSUB/MSUBU: {HI,LO} - A*B.
  - Signed/unsigned per op; uses HI/LO as they stand at the accepting edge.
  - Latency is MULT_CYCLES.
- Undefined: ops 7-10 are treated as none: not accepted, busy stays 0, HI/LO unchanged.

Test Plan:
- Reset then MTHI A=0x12345678, then MTLO A=0xCAFEBABE -> HI=0x12345678 and LO=0xCAFEBABE one cycle after each; busy never asserts.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV with B=0 -> busy 10 cycles, HI/LO unchanged.
- start=1 with flush=1, MULT A=5, B=5 -> busy stays 0, HI/LO unchanged. flush pulsed mid-countdown of a MULT -> the result still commits on schedule.
- reset driven low for 1 ns asynchronously, 3 cycles into a DIV -> busy, HI and LO are 0 immediately with no clock edge; no commit follows.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO and fixed latency.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [3:0]  count;
    logic [63:0] pend;
    logic        pend_ok;

    logic        mul_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [63:0] acc;

    logic        div_signed;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    logic        legal;
    logic        accept;
    logic        wr_hi;
    logic        wr_lo;
    logic [3:0]  nxt_cnt;
    logic [63:0] nxt_pend;
    logic        nxt_ok;

    assign busy = (count != 4'd0);
    assign acc  = {HI, LO};

    // One shared multiplier: sign- or zero-extend to 64 bits first
`ifdef MDU_MADD_EN
    assign mul_signed = (op == OP_MULT) || (op == OP_MADD) ||
                        (op == OP_MSUB);
`else
    assign mul_signed = (op == OP_MULT);
`endif
    assign ext_a = {{32{mul_signed & A[31]}}, A};
    assign ext_b = {{32{mul_signed & B[31]}}, B};
    assign prod  = ext_a * ext_b;

    // Divide magnitudes; fix signs after so INT_MIN / -1 wraps cleanly
    assign div_signed = (op == OP_DIV);
    assign dvd   = (div_signed && A[31]) ? -A : A;
    always_comb begin
        dvs = (div_signed && B[31]) ? -B : B;
        if (B == 32'd0) dvs = 32'd1;
    end
    assign q_mag = dvd / dvs;
    assign r_mag = dvd % dvs;
    assign quo   = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
    assign rem   = (div_signed && A[31]) ? -r_mag : r_mag;

    always_comb begin
        legal    = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        nxt_cnt  = 4'd0;
        nxt_pend = 64'd0;
        nxt_ok   = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: begin
                legal    = 1'b1;
                nxt_cnt  = 4'(MULT_CYCLES);
                nxt_pend = prod;
                nxt_ok   = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                legal    = 1'b1;
                nxt_cnt  = 4'(DIV_CYCLES);
                nxt_pend = {rem, quo};
                nxt_ok   = (B != 32'd0);
            end
            OP_MTHI: begin
                legal = 1'b1;
                wr_hi = 1'b1;
            end
            OP_MTLO: begin
                legal = 1'b1;
                wr_lo = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                legal    = 1'b1;
                nxt_cnt  = 4'(MULT_CYCLES);
                nxt_pend = acc + prod;
                nxt_ok   = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                legal    = 1'b1;
                nxt_cnt  = 4'(MULT_CYCLES);
                nxt_pend = acc - prod;
                nxt_ok   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign accept = start && !flush && !busy && legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI      <= 32'd0;
            LO      <= 32'd0;
            count   <= 4'd0;
            pend    <= 64'd0;
            pend_ok <= 1'b0;
        end else if (accept) begin
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;
            count   <= nxt_cnt;
            pend    <= nxt_pend;
            pend_ok <= nxt_ok;
        end else if (busy) begin
            count <= count - 4'd1;
            if (count == 4'd1 && pend_ok) begin
                HI <= pend[63:32];
                LO <= pend[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Build with +define+MDU_MADD_EN to exercise the multiply-accumulate ops.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp  = 0;
    int n_fail = 0;
    int n;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing a command while busy means the hazard unit failed to stall
    always @(negedge clk) begin
        if (reset && start && busy) begin
            n_fail++;
            $error("FAIL protocol: start=%0b while busy=%0b", start, busy);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        op    = 4'd0;
    endtask

    // Counts cycles until busy drops, bounded
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        flush = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        issue(4'd5, 32'h12345678, 32'h0);
        check("mthi_hi", HI, 32'h12345678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(4'd6, 32'hCAFEBABE, 32'h0);
        check("mtlo_lo", LO, 32'hCAFEBABE);
        check("mtlo_hi", HI, 32'h12345678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("mult_cyc", n, 32'd5);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFA);

        issue(4'd2, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("multu_cyc", n, 32'd5);
        check("multu_hi", HI, 32'h00000002);
        check("multu_lo", LO, 32'hFFFFFFFA);

        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        check("div_cyc", n, 32'd10);
        check("div_hi", HI, 32'hFFFFFFFF);
        check("div_lo", LO, 32'hFFFFFFFD);

        issue(4'd3, 32'd1234, 32'd0);
        wait_idle(n);
        check("div0_cyc", n, 32'd10);
        check("div0_hi", HI, 32'hFFFFFFFF);
        check("div0_lo", LO, 32'hFFFFFFFD);

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        check("divov_hi", HI, 32'h00000000);
        check("divov_lo", LO, 32'h80000000);

        issue(4'd4, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_cyc", n, 32'd10);
        check("divu_hi", HI, 32'd2);
        check("divu_lo", LO, 32'd14);

        flush = 1'b1;
        issue(4'd1, 32'd5, 32'd5);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        tick();
        check("flush_hi", HI, 32'd2);
        check("flush_lo", LO, 32'd14);

        issue(4'd1, 32'd7, 32'd6);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle(n);
        check("mflush_cyc", n + 2, 32'd5);
        check("mflush_hi", HI, 32'd0);
        check("mflush_lo", LO, 32'd42);

        issue(4'd5, 32'h0, 32'h0);
        issue(4'd6, 32'hFFFFFFFF, 32'h0);
        issue(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("maddu_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("maddu_cyc", n, 32'd5);
        check("maddu_hi", HI, 32'd1);
        check("maddu_lo", LO, 32'd0);
`else
        check("maddu_busy", {31'd0, busy}, 32'd0);
        tick();
        check("maddu_hi", HI, 32'd0);
        check("maddu_lo", LO, 32'hFFFFFFFF);
`endif

        issue(4'd4, 32'd100, 32'd7);
        tick();
        tick();
        check("rstdiv_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_hi", HI, 32'd0);
        check("post_lo", LO, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
